// File: rtl/pipe_adder_pkg.sv
// Shared constants and stage-register layout for the segmented pipelined adder.
package pipe_adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG   = 8;
    // Stage registers are sized for the widest supported adder; bits above WIDTH stay zero.
    localparam int MAX_WIDTH = 256;

    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
        logic [MAX_WIDTH-1:0] sum;
    } stage_reg_t;

endpackage

// File: rtl/rca_seg.sv
// Combinational SEG-bit ripple-carry segment built from per-bit full adders.
module rca_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb
);

    always_comb begin
        logic c;
        c     = cin;
        c_msb = cin;
        sum   = '0;
        for (int i = 0; i < SEG; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c_msb  = c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder, SEG bits per stage, valid/ready flow control.
// Define PIPE_ADDER_SUB_EN to add the in_sub port (A - B as A + ~B + 1).
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int STAGES = WIDTH / SEG;

    if (SEG < 1 || WIDTH % SEG != 0 || WIDTH > MAX_WIDTH) begin : g_param_check
        $error("pipe_adder: WIDTH must be a multiple of SEG (SEG >= 1) and at most MAX_WIDTH");
    end

    stage_reg_t       stage_q [STAGES];
    stage_reg_t       stage_d [STAGES];
    logic [SEG-1:0]   seg_sum [STAGES];
    logic [STAGES-1:0] seg_cout;
    logic [STAGES-1:0] seg_cmsb;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             adv;
    logic             unused_cmsb;

    logic             out_valid_reg;
    logic [WIDTH-1:0] out_sum_reg;
    logic             out_cout_reg;
    logic             out_ovf_reg;

`ifdef PIPE_ADDER_SUB_EN
    assign b_eff   = in_sub ? ~in_b : in_b;
    assign cin_eff = in_sub ? 1'b1 : in_cin;
`else
    assign b_eff   = in_b;
    assign cin_eff = in_cin;
`endif

    // Whole pipeline moves together; it only stalls when a finished result is not taken.
    assign adv      = !out_valid_reg || out_ready;
    assign in_ready = adv;

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_seg
        rca_seg #(.SEG(SEG)) u_rca (
            .a     (stage_q[gi].a[gi*SEG +: SEG]),
            .b     (stage_q[gi].b[gi*SEG +: SEG]),
            .cin   (stage_q[gi].carry),
            .sum   (seg_sum[gi]),
            .cout  (seg_cout[gi]),
            .c_msb (seg_cmsb[gi])
        );
    end

    // Only the top segment's carry-into-MSB feeds the overflow flag.
    assign unused_cmsb = ^seg_cmsb;

    always_comb begin
        stage_d = '{default: '0};
        stage_d[0].valid = in_valid;
        stage_d[0].carry = cin_eff;
        stage_d[0].a     = MAX_WIDTH'(in_a);
        stage_d[0].b     = MAX_WIDTH'(b_eff);
        for (int k = 1; k < STAGES; k++) begin
            stage_d[k]                         = stage_q[k-1];
            stage_d[k].carry                   = seg_cout[k-1];
            stage_d[k].sum[(k-1)*SEG +: SEG]   = seg_sum[k-1];
        end
        result_d = stage_q[STAGES-1].sum[WIDTH-1:0];
        result_d[(STAGES-1)*SEG +: SEG] = seg_sum[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
            out_valid_reg <= 1'b0;
            out_sum_reg   <= '0;
            out_cout_reg  <= 1'b0;
            out_ovf_reg   <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
            out_valid_reg <= stage_q[STAGES-1].valid;
            out_sum_reg   <= result_d;
            out_cout_reg  <= seg_cout[STAGES-1];
            out_ovf_reg   <= seg_cout[STAGES-1] ^ seg_cmsb[STAGES-1];
        end
    end

    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign out_cout  = out_cout_reg;
    assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder (WIDTH=32, SEG=8, four-cycle latency).
module tb_pipe_adder;

    localparam int WIDTH  = 32;
    localparam int SEG    = 8;
    localparam int STAGES = WIDTH / SEG;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_cin = 1'b0;
`ifdef PIPE_ADDER_SUB_EN
    logic             in_sub = 1'b0;
`endif
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   pop_cycles[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;
    int   cyc    = 0;

    pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef PIPE_ADDER_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "time limit");
    end

    // Reference: signed overflow from operand/result signs, independent of carries.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        exp_t r;
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] bb;
        logic             c;
        bb     = sub ? ~b : b;
        c      = sub ? 1'b1 : cin;
        full   = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(c);
        r.sum  = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        r.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            pops++;
            pop_cycles.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got sum=%h cout=%b ovf=%b, required no output", out_sum, out_cout, out_ovf);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_sum, out_cout, out_ovf} !== mon_e) begin
                    errors++;
                    $display("FAIL result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                             out_sum, out_cout, out_ovf, mon_e.sum, mon_e.cout, mon_e.ovf);
                end else begin
                    $display("result sum=%h cout=%b ovf=%b ok", out_sum, out_cout, out_ovf);
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub);
        int guard;
        guard    = 0;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
`ifdef PIPE_ADDER_SUB_EN
        in_sub   = sub;
`endif
        @(negedge clk);
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept: in_ready=%b after %0d cycles, required 1", in_ready, guard);
        end
        @(posedge clk);
        exp_q.push_back(model(a, b, cin, sub));
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results pending after %0d cycles, required 0", exp_q.size(), guard);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
        if (out_sum !== '0) begin errors++; $display("FAIL reset_sum: got %h, required 0", out_sum); end
        if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b, required 0", out_cout); end
        if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b, required 0", out_ovf); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", in_ready); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks += 2;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b, required 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b, required 0", out_valid); end
        @(posedge clk);
        #1;
        $display("test_reset done");
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        for (int k = 1; k <= STAGES; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid !== (k == STAGES)) begin
                errors++;
                $display("FAIL latency: out_valid=%b after %0d edges, required %b", out_valid, k, (k == STAGES));
            end
        end
        checks++;
        if ({out_sum, out_cout, out_ovf} !== {32'h0000_0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wrap: got sum=%h cout=%b ovf=%b, required sum=00000000 cout=1 ovf=0", out_sum, out_cout, out_ovf);
        end
        drain();
        $display("test_latency done");
    endtask

    task automatic test_corner();
        out_ready = 1'b1;
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
        send(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0);
        drain();
        $display("test_corner done");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        pop_cycles.delete();
        for (int i = 0; i < 10; i++) begin
            send(32'(i), 32'(i * 3), 1'b0, 1'b0);
        end
        drain();
        checks++;
        if (pop_cycles.size() != 10) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, required 10", pop_cycles.size());
        end
        for (int i = 1; i < pop_cycles.size(); i++) begin
            checks++;
            if (pop_cycles[i] - pop_cycles[i-1] != 1) begin
                errors++;
                $display("FAIL b2b_gap: result %0d came %0d cycles after previous, required 1", i, pop_cycles[i] - pop_cycles[i-1]);
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_bubbles();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_a = $urandom;
                in_b = $urandom;
                in_cin = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        drain();
        $display("test_bubbles done");
    endtask

    task automatic test_stall();
        int pend;
        out_ready = 1'b0;
        for (int i = 0; i < STAGES + 1; i++) begin
            send(32'h8000_0000 + 32'(i), 32'h8000_0000, 1'b0, 1'b0);
        end
        pend = pops;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks += 3;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b, required 0 (cycle %0d)", in_ready, c); end
            if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b, required 1 (cycle %0d)", out_valid, c); end
            if ({out_sum, out_cout, out_ovf} !== exp_q[0]) begin
                errors++;
                $display("FAIL stall_hold: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                         out_sum, out_cout, out_ovf, exp_q[0].sum, exp_q[0].cout, exp_q[0].ovf);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();
        checks++;
        if (pops - pend != STAGES + 1) begin
            errors++;
            $display("FAIL stall_count: got %0d results, required %0d", pops - pend, STAGES + 1);
        end
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_dup: out_valid=%b after drain, required 0", out_valid); end
        end
        @(posedge clk);
        #1;
        $display("test_stall done");
    endtask

    task automatic test_reset_midflight();
        int pend;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(32'h0000_0100 + 32'(i), 32'h0000_0010, 1'b0, 1'b0);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b, required 1", out_valid); end
        rst = 1'b1;
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b, required 0", out_valid); end
        if (out_sum !== '0) begin errors++; $display("FAIL midreset_sum: got %h, required 0", out_sum); end
        if (out_cout !== 1'b0) begin errors++; $display("FAIL midreset_cout: got %b, required 0", out_cout); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b, required 1", in_ready); end
        exp_q.delete();
        pend = pops;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL stale_after_reset: out_valid=%b sum=%h, required 0", out_valid, out_sum); end
        end
        checks++;
        if (pops != pend) begin errors++; $display("FAIL stale_count: got %0d results, required 0", pops - pend); end
        @(posedge clk);
        #1;
        $display("test_reset_midflight done");
    endtask

`ifdef PIPE_ADDER_SUB_EN
    task automatic test_sub();
        out_ready = 1'b1;
        send(32'd5, 32'd3, 1'b0, 1'b1);
        send(32'd3, 32'd5, 1'b0, 1'b1);
        send(32'd5, 32'd3, 1'b1, 1'b1);
        send(32'h8000_0000, 32'd1, 1'b0, 1'b1);
        send(32'd7, 32'd9, 1'b1, 1'b0);
        drain();
        $display("test_sub done");
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_corner();
        test_back_to_back();
        test_bubbles();
        test_stall();
        test_reset_midflight();
`ifdef PIPE_ADDER_SUB_EN
        test_sub();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter SEG, default 8, bits added per pipeline stage; STAGES = WIDTH/SEG.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  operand set accepted on the current edge when high with in_valid.
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B.
REQ-009 in_cin  input  1  carry-in.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 out_sum  output  WIDTH  sum, modulo 2^WIDTH.
REQ-013 out_cout  output  1  carry out of bit WIDTH-1.
REQ-014 out_ovf  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL elaborate-time error if WIDTH % SEG != 0 or SEG < 1.
REQ-016 Stage k (0..STAGES-1) SHALL add bits [k*SEG+SEG-1:k*SEG] of A and B with the carry registered by stage k-1; stage 0 uses the registered in_cin.
REQ-017 Unconsumed upper operand segments SHALL be skew-registered forward; completed lower sum segments SHALL be deskew-registered so all bits of one result emerge together.
REQ-018 Pipeline SHALL advance (adv) when !out_valid or out_ready; all stage registers hold when adv=0.
REQ-019 in_ready SHALL equal adv (combinational from out_valid, out_ready).
REQ-020 Latency SHALL be exactly STAGES cycles: set accepted at edge t appears with out_valid=1 after edge t+STAGES-1+1, absent stalls.
REQ-021 Throughput SHALL be one result per cycle with out_ready held high; no bubbles inserted.
REQ-022 A valid bit SHALL travel with each stage; empty stages are bubbles and SHALL NOT raise out_valid.
REQ-023 out_sum/out_cout/out_ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 out_ovf SHALL equal carry into MSB XOR carry out of MSB.
REQ-025 in_valid=0 with adv=1 SHALL insert a bubble; operand values then are don't-care.

Reset
REQ-026 On rst all valid bits SHALL clear immediately; out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
REQ-027 Reset mid-operation SHALL discard all in-flight results; none SHALL be emitted after rst deasserts.
REQ-028 in_ready SHALL be 1 during and after reset (pipeline empty).

Configuration
REQ-029 With PIPE_ADDER_SUB_EN defined, port in_sub (input, 1) SHALL exist; in_sub=1 computes A + ~B + 1 (in_cin ignored), out_cout=1 meaning no borrow.
REQ-030 Without PIPE_ADDER_SUB_EN, in_sub SHALL NOT exist and the block SHALL always compute A + B + in_cin.

Structure
REQ-031 Package pipe_adder_pkg SHALL hold default WIDTH/SEG constants and the stage-register struct (valid, carry, skewed operands, partial sum).
REQ-032 One sub-module, rca_seg, SHALL implement the combinational SEG-bit ripple-carry segment built from per-bit full-adder equations; instantiated once per stage.

Verification (WIDTH=32, SEG=8, latency 4)
REQ-033 A=FFFFFFFF, B=1, cin=0 -> after 4 cycles sum=00000000, cout=1, ovf=0.
REQ-034 A=7FFFFFFF, B=1, cin=0 -> sum=80000000, cout=0, ovf=1; A=FFFFFFFF, B=FFFFFFFF, cin=1 -> sum=FFFFFFFF, cout=1, ovf=0.
REQ-035 Ten back-to-back sets (A=i, B=i*3), out_ready=1 -> ten results on consecutive cycles, in order, sum=4*i.
REQ-036 out_ready=0 for 6 cycles with pipeline full -> in_ready=0, out_* frozen, no loss or duplication after release.
REQ-037 rst pulsed with 3 sets in flight -> out_valid=0 immediately, no stale result after release.
REQ-038 With PIPE_ADDER_SUB_EN: A=5, B=3, in_sub=1 -> sum=2, cout=1; A=3, B=5 -> sum=FFFFFFFE, cout=0.
